// File: rtl/joy_db15_responder_pkg.sv
// Shared types and constants for the DB15 joystick responder.
package joy_db15_responder_pkg;

  localparam int PLAYER_BITS_DEF = 12;
  localparam int SYNC_STAGES_DEF = 2;

  // state | meaning
  // LOAD  | host holds JOY_LOAD low, shift chain tracks the live player words
  // SHIFT | frame in flight, each host JOY_CLK rise presents the next bit
  // DRAIN | frame consumed (or idle after reset), line held at 1
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Button positions inside one player word.
  localparam int BTN_R      = 0;
  localparam int BTN_L      = 1;
  localparam int BTN_D      = 2;
  localparam int BTN_U      = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_C      = 6;
  localparam int BTN_X      = 7;
  localparam int BTN_Y      = 8;
  localparam int BTN_Z      = 9;
  localparam int BTN_START  = 10;
  localparam int BTN_SELECT = 11;

endpackage

// File: rtl/joy_db15_responder_if.sv
// Host-side DB15 serial link: shift clock, parallel load and serial data.
interface joy_db15_responder_if;

  logic JOY_CLK;
  logic JOY_LOAD;
  logic JOY_DATA;

  modport master (output JOY_CLK, output JOY_LOAD, input JOY_DATA);
  modport slave  (input JOY_CLK, input JOY_LOAD, output JOY_DATA);

endinterface

// File: rtl/joy_db15_responder_sync_edge.sv
// Multi-stage synchroniser for one async host line plus a rise detector.
// Reset value is 1 so an idle-high line produces no spurious edge.
module joy_db15_responder_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the async input through the chain; keep last cycle's level for edge detect.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // Chain registers, all ones in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/joy_db15_responder.sv
// Device-side DB15 joystick adapter emulator: parallel-in/serial-out chain
// answering the host's JOY_LOAD / JOY_CLK with both player words, LSB first.
module joy_db15_responder
  import joy_db15_responder_pkg::*;
#(
  parameter int PLAYER_BITS = PLAYER_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [PLAYER_BITS-1:0]                 joystick1,
  input  logic [PLAYER_BITS-1:0]                 joystick2,
  joy_db15_responder_if.slave                    link,
  output logic                                   frame_done,
  output logic [$clog2(2*PLAYER_BITS+1)-1:0]     shift_cnt,
  output logic                                   overrun
);

  localparam int N  = 2 * PLAYER_BITS;
  localparam int CW = $clog2(N + 1);

  logic clk_rise, clk_level_unused;
  logic load_lvl, load_rise_unused;

  state_t         state_q, state_d;
  logic [N-1:0]   shift_reg_q, shift_reg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           overrun_q, overrun_d;
  logic           frame_done_q, frame_done_d;

  joy_db15_responder_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (link.JOY_CLK),
    .level   (clk_level_unused),
    .rise    (clk_rise)
  );

  joy_db15_responder_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (link.JOY_LOAD),
    .level   (load_lvl),
    .rise    (load_rise_unused)
  );

  // Next-state logic: a low LOAD overrides everything, including a coincident
  // CLK edge. Leaving LOAD consumes the cycle, so a CLK rise arriving together
  // with the LOAD rise is dropped.
  always_comb begin
    state_d      = state_q;
    shift_reg_d  = shift_reg_q;
    cnt_d        = cnt_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    if (!load_lvl) begin
      state_d     = LOAD;
      shift_reg_d = ~{joystick2, joystick1};
      cnt_d       = '0;
      overrun_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD:  state_d = SHIFT;
        SHIFT: begin
          if (clk_rise) begin
            // Ones fill from the top, so the drained chain reads back as all 1s.
            shift_reg_d = {1'b1, shift_reg_q[N-1:1]};
            cnt_d       = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
              frame_done_d = 1'b1;
              state_d      = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (clk_rise) overrun_d = 1'b1;
        end
        default: state_d = DRAIN;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= DRAIN;
      shift_reg_q  <= '1;
      cnt_q        <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_reg_q  <= shift_reg_d;
      cnt_q        <= cnt_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign link.JOY_DATA = shift_reg_q[0];
  assign frame_done    = frame_done_q;
  assign shift_cnt     = cnt_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_joy_db15_responder.sv
// Bench for joy_db15_responder: acts as the DB15 host and checks the serial
// stream against a bit-list model built from the player words.
module tb_joy_db15_responder;
  import joy_db15_responder_pkg::*;

  localparam int P  = 12;
  localparam int N  = 2 * P;
  localparam int PH = 5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [P-1:0] joystick1, joystick2;
  logic         frame_done, overrun;
  logic [4:0]   shift_cnt;

  joy_db15_responder_if link();

  joy_db15_responder #(.PLAYER_BITS(P), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .link       (link),
    .frame_done (frame_done),
    .shift_cnt  (shift_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int fd_count = 0;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  // Reference model: list of expected line levels and count of host edges.
  logic exp_bits [N];
  int   k;

  task automatic model_load(input logic [P-1:0] a, input logic [P-1:0] b);
    for (int i = 0; i < P; i++) begin
      exp_bits[i]     = !a[i];
      exp_bits[P + i] = !b[i];
    end
    k = 0;
  endtask

  function automatic logic exp_data();
    return (k < N) ? exp_bits[k] : 1'b1;
  endfunction

  function automatic int exp_cnt();
    return (k < N) ? k : N;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_load();
    link.JOY_LOAD = 1'b0;
    cyc(PH);
    link.JOY_LOAD = 1'b1;
    model_load(joystick1, joystick2);
    cyc(PH);
  endtask

  task automatic host_clk();
    link.JOY_CLK = 1'b0;
    cyc(PH);
    link.JOY_CLK = 1'b1;
    k++;
    cyc(PH);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    link.JOY_CLK = 1'b1;
    link.JOY_LOAD = 1'b1;
    joystick1 = '0;
    joystick2 = '0;
    cyc(3);
    if (link.JOY_DATA !== 1'b1) begin n_fail++; $display("FAIL reset_data: got %b want 1", link.JOY_DATA); end
    n_cmp++;
    if (shift_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", shift_cnt); end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    n_cmp++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    n_cmp++;
    reset_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_first_bit();
    int fd0;
    joystick1 = P'(1 << BTN_R);
    joystick2 = '0;
    host_load();
    fd0 = fd_count;
    for (int e = 0; e < N; e++) begin
      if (link.JOY_DATA !== ((e == 0) ? 1'b0 : 1'b1)) begin
        n_fail++; $display("FAIL t1_bit%0d: got %b want %b", e, link.JOY_DATA, (e != 0));
      end
      n_cmp++;
      if (e == N - 1 && fd_count !== fd0) begin
        n_fail++; $display("FAIL t1_early_fd: got %0d pulses want 0", fd_count - fd0);
      end
      if (e == N - 1) n_cmp++;
      host_clk();
    end
    if (fd_count - fd0 !== 1) begin n_fail++; $display("FAIL t1_fd: got %0d pulses want 1", fd_count - fd0); end
    n_cmp++;
    if (shift_cnt !== 5'd24) begin n_fail++; $display("FAIL t1_cnt: got %0d want 24", shift_cnt); end
    n_cmp++;
    if (link.JOY_DATA !== 1'b1) begin n_fail++; $display("FAIL t1_drain: got %b want 1", link.JOY_DATA); end
    n_cmp++;
  endtask

  task automatic test_last_bit();
    joystick1 = '0;
    joystick2 = P'(1 << BTN_SELECT);
    host_load();
    for (int e = 0; e < N; e++) begin
      if (link.JOY_DATA !== ((e == N - 1) ? 1'b0 : 1'b1)) begin
        n_fail++; $display("FAIL t2_bit%0d: got %b want %b", e, link.JOY_DATA, (e != N - 1));
      end
      n_cmp++;
      host_clk();
    end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL t2_ovr: got %b want 0", overrun); end
    n_cmp++;
  endtask

  task automatic test_overrun();
    joystick1 = P'($urandom);
    joystick2 = P'($urandom);
    host_load();
    repeat (N + 2) host_clk();
    if (link.JOY_DATA !== 1'b1) begin n_fail++; $display("FAIL t3_data: got %b want 1", link.JOY_DATA); end
    n_cmp++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL t3_ovr: got %b want 1", overrun); end
    n_cmp++;
    if (shift_cnt !== 5'd24) begin n_fail++; $display("FAIL t3_cnt_hold: got %0d want 24", shift_cnt); end
    n_cmp++;
    host_load();
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL t3_ovr_clr: got %b want 0", overrun); end
    n_cmp++;
    if (shift_cnt !== 5'd0) begin n_fail++; $display("FAIL t3_cnt_clr: got %0d want 0", shift_cnt); end
    n_cmp++;
  endtask

  task automatic test_reload();
    int fd0;
    joystick1 = P'($urandom);
    joystick2 = P'($urandom);
    host_load();
    fd0 = fd_count;
    repeat (10) host_clk();
    joystick1 = 12'hFFF;
    host_load();
    for (int e = 0; e < P; e++) begin
      if (link.JOY_DATA !== 1'b0) begin n_fail++; $display("FAIL t4_bit%0d: got %b want 0", e, link.JOY_DATA); end
      n_cmp++;
      host_clk();
    end
    if (fd_count !== fd0) begin n_fail++; $display("FAIL t4_no_fd: got %0d pulses want 0", fd_count - fd0); end
    n_cmp++;
    if (shift_cnt !== 5'd12) begin n_fail++; $display("FAIL t4_cnt: got %0d want 12", shift_cnt); end
    n_cmp++;
  endtask

  task automatic test_mid_change_and_coincident();
    joystick1 = P'($urandom);
    joystick2 = P'($urandom);
    host_load();
    repeat (3) host_clk();
    joystick1 = ~joystick1;
    joystick2 = ~joystick2;
    for (int e = 3; e < N; e++) begin
      if (link.JOY_DATA !== exp_data()) begin
        n_fail++; $display("FAIL t5_bit%0d: got %b want %b", e, link.JOY_DATA, exp_data());
      end
      n_cmp++;
      host_clk();
    end
    link.JOY_LOAD = 1'b0;
    link.JOY_CLK = 1'b0;
    cyc(PH);
    link.JOY_LOAD = 1'b1;
    link.JOY_CLK = 1'b1;
    model_load(joystick1, joystick2);
    cyc(PH);
    if (shift_cnt !== 5'd0) begin n_fail++; $display("FAIL t5_coinc_cnt: got %0d want 0", shift_cnt); end
    n_cmp++;
    if (link.JOY_DATA !== exp_bits[0]) begin
      n_fail++; $display("FAIL t5_coinc_data: got %b want %b", link.JOY_DATA, exp_bits[0]);
    end
    n_cmp++;
    host_clk();
    if (shift_cnt !== 5'd1) begin n_fail++; $display("FAIL t5_after_cnt: got %0d want 1", shift_cnt); end
    n_cmp++;
  endtask

  task automatic test_reset_midframe();
    joystick1 = P'(1 << BTN_X);
    joystick2 = '0;
    host_load();
    repeat (7) host_clk();
    if (link.JOY_DATA !== 1'b0) begin n_fail++; $display("FAIL t6_pre: got %b want 0", link.JOY_DATA); end
    n_cmp++;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    if (link.JOY_DATA !== 1'b1) begin n_fail++; $display("FAIL t6_data: got %b want 1", link.JOY_DATA); end
    n_cmp++;
    if (shift_cnt !== 5'd0) begin n_fail++; $display("FAIL t6_cnt: got %0d want 0", shift_cnt); end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL t6_fd: got %b want 0", frame_done); end
    n_cmp++;
    cyc(3);
    reset_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_random();
    int fd0, nclk, want_fd;
    for (int f = 0; f < 16; f++) begin
      joystick1 = P'($urandom);
      joystick2 = P'($urandom);
      host_load();
      fd0 = fd_count;
      nclk = $urandom_range(0, N + 3);
      for (int e = 0; e < nclk; e++) begin
        if ($urandom_range(0, 3) == 0) joystick1 = P'($urandom);
        host_clk();
        if (link.JOY_DATA !== exp_data()) begin
          n_fail++; $display("FAIL rnd_data f%0d e%0d: got %b want %b", f, k, link.JOY_DATA, exp_data());
        end
        n_cmp++;
        if (shift_cnt !== 5'(exp_cnt())) begin
          n_fail++; $display("FAIL rnd_cnt f%0d: got %0d want %0d", f, shift_cnt, exp_cnt());
        end
        n_cmp++;
        if (overrun !== (k > N)) begin
          n_fail++; $display("FAIL rnd_ovr f%0d e%0d: got %b want %b", f, k, overrun, (k > N));
        end
        n_cmp++;
      end
      want_fd = (nclk >= N) ? 1 : 0;
      if (fd_count - fd0 !== want_fd) begin
        n_fail++; $display("FAIL rnd_fd f%0d: got %0d pulses want %0d", f, fd_count - fd0, want_fd);
      end
      n_cmp++;
    end
  endtask

  initial begin
    test_reset();
    test_first_bit();
    test_last_bit();
    test_overrun();
    test_reload();
    test_mid_change_and_coincident();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
